pulse_sweep_sched: RTL and testbench



---
 rtl/pulse_pkg.sv | 15 +
 rtl/shot_counter.sv | 41 ++++
 rtl/pulse_sweep_sched.sv | 129 ++++++++++++
 tb/tb_pulse_sweep_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared types and default widths for the pulse sweep scheduler.
package pulse_pkg;

    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned IDX_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        WAIT_ACK,
        DONE
    } state_t;

endpackage

// File: rtl/shot_counter.sv
// Cycle and shot counters for one sweep point, with period-wrap and last-shot detect.
module shot_counter
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    input  logic [IDX_W-1:0] shots,
    output logic             shot_wrap,
    output logic             point_last
);

    logic [CNT_W-1:0] cyc_cnt;
    logic [IDX_W-1:0] shot_cnt;

    assign shot_wrap  = enable && (cyc_cnt == period);
    assign point_last = shot_wrap && (shot_cnt == shots - IDX_W'(1));

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            shot_cnt <= '0;
        end else if (clear) begin
            cyc_cnt  <= '0;
            shot_cnt <= '0;
        end else if (enable) begin
            if (cyc_cnt == period) begin
                cyc_cnt  <= '0;
                shot_cnt <= shot_cnt + IDX_W'(1);
            end else begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_sweep_sched.sv
// Delay-sweep scheduler: runs shots_per_point generator periods per point, then
// holds the generator off and waits for the readout ack before stepping the delay.
module pulse_sweep_sched
    import pulse_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] base_delay,
    input  logic [CNT_W-1:0] delay_step,
    input  logic [IDX_W-1:0] num_points,
    input  logic [IDX_W-1:0] shots_per_point,
    input  logic             point_ack,
    output logic             run_en,
    output logic [CNT_W-1:0] delay_out,
    output logic [IDX_W-1:0] point_idx,
    output logic             point_done,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, step_q;
    logic [IDX_W-1:0] num_pts_q, shots_q;

    logic start_ok, cfg_ok, accept, reject, last_point, advance;
    logic shot_wrap, point_last;
    logic run_en_d, busy_d, point_done_d, done_d;

    shot_counter #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_shot_counter (
        .clk_pll    (clk_pll),
        .reset      (reset),
        .clear      (state_q == ARM),
        .enable     (state_q == RUN),
        .period     (period_q),
        .shots      (shots_q),
        .shot_wrap  (shot_wrap),
        .point_last (point_last)
    );

    // abort masks start so a same-cycle start+abort is dropped
    assign start_ok   = start && !abort && (state_q == IDLE || state_q == DONE);
    assign cfg_ok     = (period != '0) && (num_points != '0) && (shots_per_point != '0);
    assign accept     = start_ok && cfg_ok;
    assign reject     = start_ok && !cfg_ok;
    assign last_point = (point_idx == num_pts_q - IDX_W'(1));
    assign advance    = (state_q == WAIT_ACK) && point_ack && !abort && !last_point;

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     if (accept) state_d = ARM;
                ARM:      state_d = RUN;
                RUN:      if (point_last) state_d = WAIT_ACK;
                WAIT_ACK: if (point_ack) state_d = last_point ? DONE : ARM;
                DONE:     state_d = accept ? ARM : IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        run_en_d     = (state_d == RUN);
        busy_d       = (state_d == ARM) || (state_d == RUN) || (state_d == WAIT_ACK);
        point_done_d = (state_d == WAIT_ACK);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            run_en     <= 1'b0;
            busy       <= 1'b0;
            point_done <= 1'b0;
            done       <= 1'b0;
        end else begin
            run_en     <= run_en_d;
            busy       <= busy_d;
            point_done <= point_done_d;
            done       <= done_d;
        end
    end

    always_ff @(posedge clk_pll or posedge reset) begin
        if (reset) begin
            period_q  <= '0;
            step_q    <= '0;
            num_pts_q <= '0;
            shots_q   <= '0;
            delay_out <= '0;
            point_idx <= '0;
            cfg_err   <= 1'b0;
        end else begin
            if (accept) begin
                period_q  <= period;
                step_q    <= delay_step;
                num_pts_q <= num_points;
                shots_q   <= shots_per_point;
                delay_out <= base_delay;
                point_idx <= '0;
                cfg_err   <= 1'b0;
            end else begin
                if (reject) cfg_err <= 1'b1;
                if (advance) begin
                    point_idx <= point_idx + IDX_W'(1);
                    delay_out <= delay_out + step_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_sweep_sched.sv
// Directed bench for pulse_sweep_sched with hand-computed expectations.
module tb_pulse_sweep_sched;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned IDX_W = 16;

    logic             clk_pll = 1'b0;
    logic             reset   = 1'b1;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [CNT_W-1:0] period  = '0;
    logic [CNT_W-1:0] base_delay = '0;
    logic [CNT_W-1:0] delay_step = '0;
    logic [IDX_W-1:0] num_points = '0;
    logic [IDX_W-1:0] shots_per_point = '0;
    logic             point_ack = 1'b0;
    logic             run_en;
    logic [CNT_W-1:0] delay_out;
    logic [IDX_W-1:0] point_idx;
    logic             point_done;
    logic             busy;
    logic             done;
    logic             cfg_err;

    int tests = 0;
    int fails = 0;
    int n;

    pulse_sweep_sched #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) dut (
        .clk_pll         (clk_pll),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .period          (period),
        .base_delay      (base_delay),
        .delay_step      (delay_step),
        .num_points      (num_points),
        .shots_per_point (shots_per_point),
        .point_ack       (point_ack),
        .run_en          (run_en),
        .delay_out       (delay_out),
        .point_idx       (point_idx),
        .point_done      (point_done),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 clk_pll = ~clk_pll;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ack_point();
        point_ack = 1'b1;
        step();
        point_ack = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] p, input logic [31:0] b, input logic [31:0] s,
                           input logic [15:0] np, input logic [15:0] sh);
        period = p; base_delay = b; delay_step = s; num_points = np; shots_per_point = sh;
    endtask

    // Count run_en-high cycles until point_done rises; bounded.
    task automatic burst(input int n0, output int cnt);
        cnt = n0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (i == 0 && n0 == 0) check("arm_one_cycle", {31'd0, run_en}, 32'd1);
            if (run_en) cnt++;
            if (point_done) break;
        end
        check("burst_timeout", {31'd0, point_done}, 32'd1);
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_run_en", {31'd0, run_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_delay", delay_out, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        reset = 1'b0;
        step();

        // 1. Basic sweep: 3 points x 2 shots x 10 clocks
        set_cfg(32'd9, 32'd100, 32'd20, 16'd3, 16'd2);
        pulse_start();
        check("t1_arm_busy", {31'd0, busy}, 32'd1);
        check("t1_arm_run_en", {31'd0, run_en}, 32'd0);
        check("t1_delay0", delay_out, 32'd100);
        check("t1_idx0", {16'd0, point_idx}, 32'd0);
        burst(0, n);
        check("t1_burst0", n, 32'd20);
        check("t1_wait_run_en", {31'd0, run_en}, 32'd0);
        repeat (5) step();
        check("t1_still_waiting", {31'd0, point_done}, 32'd1);
        ack_point();
        check("t1_arm1_pd", {31'd0, point_done}, 32'd0);
        check("t1_delay1", delay_out, 32'd120);
        check("t1_idx1", {16'd0, point_idx}, 32'd1);
        burst(0, n);
        check("t1_burst1", n, 32'd20);
        repeat (5) step();
        ack_point();
        check("t1_delay2", delay_out, 32'd140);
        check("t1_idx2", {16'd0, point_idx}, 32'd2);
        burst(0, n);
        check("t1_burst2", n, 32'd20);
        repeat (5) step();
        ack_point();
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_done_busy", {31'd0, busy}, 32'd0);
        step();
        check("t1_done_single", {31'd0, done}, 32'd0);
        check("t1_hold_delay", delay_out, 32'd140);
        check("t1_hold_idx", {16'd0, point_idx}, 32'd2);

        // 2. Setup rejection, then a valid start clears cfg_err
        set_cfg(32'd9, 32'd100, 32'd20, 16'd3, 16'd0);
        pulse_start();
        check("t2_cfg_err", {31'd0, cfg_err}, 32'd1);
        check("t2_busy", {31'd0, busy}, 32'd0);
        step(); step();
        check("t2_run_en", {31'd0, run_en}, 32'd0);
        check("t2_busy_later", {31'd0, busy}, 32'd0);
        set_cfg(32'd3, 32'd7, 32'd1, 16'd1, 16'd1);
        pulse_start();
        check("t2_cfg_err_clr", {31'd0, cfg_err}, 32'd0);
        check("t2_busy_on", {31'd0, busy}, 32'd1);
        burst(0, n);
        check("t2_burst", n, 32'd4);
        ack_point();
        check("t2_done", {31'd0, done}, 32'd1);
        step();

        // 3. Abort mid-RUN of point 1
        set_cfg(32'd9, 32'd100, 32'd20, 16'd3, 16'd2);
        pulse_start();
        burst(0, n);
        ack_point();
        repeat (7) step();
        check("t3_running", {31'd0, run_en}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t3_run_en", {31'd0, run_en}, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_no_done", {31'd0, done}, 32'd0);
        step();
        check("t3_no_done_later", {31'd0, done}, 32'd0);
        pulse_start();
        check("t3_restart_delay", delay_out, 32'd100);
        check("t3_restart_idx", {16'd0, point_idx}, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // 4. abort + point_ack together in WAIT_ACK
        pulse_start();
        burst(0, n);
        abort = 1'b1;
        point_ack = 1'b1;
        step();
        abort = 1'b0;
        point_ack = 1'b0;
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_pd", {31'd0, point_done}, 32'd0);
        check("t4_idx", {16'd0, point_idx}, 32'd0);
        check("t4_delay", delay_out, 32'd100);
        step();
        check("t4_no_done", {31'd0, done}, 32'd0);

        // 5. start, point_ack and period change during RUN are ignored
        set_cfg(32'd9, 32'd100, 32'd20, 16'd2, 16'd2);
        pulse_start();
        n = 0;
        repeat (5) begin
            step();
            if (run_en) n++;
        end
        start = 1'b1;
        point_ack = 1'b1;
        period = 32'd3;
        step();
        if (run_en) n++;
        start = 1'b0;
        point_ack = 1'b0;
        burst(n, n);
        check("t5_burst0", n, 32'd20);
        check("t5_idx", {16'd0, point_idx}, 32'd0);
        check("t5_delay", delay_out, 32'd100);
        ack_point();
        burst(0, n);
        check("t5_burst1", n, 32'd20);
        ack_point();
        check("t5_done", {31'd0, done}, 32'd1);
        step();

        // 6. Delay accumulator wraps modulo 2^32
        set_cfg(32'd1, 32'hFFFF_FFF0, 32'h20, 16'd2, 16'd1);
        pulse_start();
        check("t6_delay0", delay_out, 32'hFFFF_FFF0);
        burst(0, n);
        check("t6_burst", n, 32'd2);
        ack_point();
        check("t6_delay1", delay_out, 32'h10);
        burst(0, n);
        ack_point();
        check("t6_done", {31'd0, done}, 32'd1);
        step();

        // 7. Asynchronous reset between edges in WAIT_ACK
        set_cfg(32'd2, 32'd55, 32'd5, 16'd2, 16'd1);
        pulse_start();
        burst(0, n);
        check("t7_pre_pd", {31'd0, point_done}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t7_pd", {31'd0, point_done}, 32'd0);
        check("t7_busy", {31'd0, busy}, 32'd0);
        check("t7_delay", delay_out, 32'd0);
        check("t7_idx", {16'd0, point_idx}, 32'd0);
        check("t7_run_en", {31'd0, run_en}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("t7_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
